// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I FETCH/DECODE/EXE/MEM/WB sequencer with memory wait timeout and fault pulses
module multicycle_control_unit #(
    parameter bit MEM_WAIT_EN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_code,
    input  logic        d_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic [3:0]  alu_controls,
    output logic        reg_wr_en,
    output logic        d_wr_en,
    output logic        d_rd_en,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RegWdataSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic [2:0]  d_func3,
    output logic        illegal_instr,
    output logic        mem_fault,
    output logic [3:0]  state_o
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXE = 4'd2, S_MEM = 4'd3, S_WB = 4'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [3:0]       r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic             w_f7b;
    logic             w_is_r, w_is_i, w_is_il, w_is_s, w_is_b, w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
    logic             w_legal, w_mem_op, w_wr_class, w_mem_done, w_mem_to, w_run;
    logic             w_fetch, w_decode, w_exe, w_mem, w_wb;
    logic             w_unused;

    assign w_op       = instr_code[6:0];
    assign w_f3       = instr_code[14:12];
    assign w_f7b      = instr_code[30];
    assign w_unused   = &{1'b0, instr_code[31], instr_code[29:15], instr_code[11:7]};
    assign w_is_r     = w_op == 7'b0110011;
    assign w_is_i     = w_op == 7'b0010011;
    assign w_is_il    = w_op == 7'b0000011;
    assign w_is_s     = w_op == 7'b0100011;
    assign w_is_b     = w_op == 7'b1100011;
    assign w_is_lui   = w_op == 7'b0110111;
    assign w_is_auipc = w_op == 7'b0010111;
    assign w_is_jal   = w_op == 7'b1101111;
    assign w_is_jalr  = w_op == 7'b1100111;
    assign w_mem_op   = w_is_il | w_is_s;
    assign w_wr_class = w_is_r | w_is_i | w_is_lui | w_is_auipc | w_is_jal | w_is_jalr;
    assign w_legal    = w_wr_class | w_mem_op | w_is_b;
    assign w_fetch    = r_state == S_FETCH;
    assign w_decode   = r_state == S_DECODE;
    assign w_exe      = r_state == S_EXE;
    assign w_mem      = r_state == S_MEM;
    assign w_wb       = r_state == S_WB;
    assign w_run      = !reset;
    // d_ready on the last allowed cycle counts as success, so the timeout only fires without it
    assign w_mem_done = !MEM_WAIT_EN || d_ready;
    assign w_mem_to   = MEM_WAIT_EN && (TIMEOUT_CYCLES > 0) && !d_ready && (r_cnt == CNT_LAST);

    // State register and MEM wait counter (cleared outside MEM, saturating inside)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= !w_mem ? '0 : (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    // Next-state selection
    always_comb begin
        w_next = w_fetch  ? S_DECODE :
                 w_decode ? (w_legal ? S_EXE : S_FETCH) :
                 w_exe    ? (w_mem_op ? S_MEM : S_FETCH) :
                 w_mem    ? ((w_mem_done && w_is_il) ? S_WB : (w_mem_done || w_mem_to) ? S_FETCH : S_MEM) :
                 S_FETCH;
    end

    // Datapath controls decoded from state and instruction; strobes are forced low during reset
    always_comb begin
        ir_en         = w_run && w_fetch;
        pc_en         = w_run && ((w_decode && !w_legal) || (w_exe && !w_mem_op) ||
                                  (w_mem && ((w_mem_done && w_is_s) || w_mem_to)) || w_wb);
        reg_wr_en     = w_run && ((w_exe && w_wr_class) || w_wb);
        d_wr_en       = w_run && w_mem && w_is_s;
        d_rd_en       = w_run && w_mem && w_is_il;
        illegal_instr = w_run && w_decode && !w_legal;
        mem_fault     = w_run && w_mem && w_mem_to;
        alu_controls  = !w_exe  ? 4'b0000 :
                        w_is_r  ? {w_f7b, w_f3} :
                        w_is_i  ? {w_f7b && (w_f3 == 3'b101), w_f3} :
                        w_is_b  ? {1'b0, w_f3} : 4'b0000;
        aluSrcMuxSel  = w_exe && (w_is_i | w_mem_op | w_is_jalr);
        RegWdataSel   = w_wb ? 3'b001 :
                        !w_exe ? 3'b000 :
                        (w_is_jal | w_is_jalr) ? 3'b100 :
                        w_is_lui ? 3'b010 :
                        w_is_auipc ? 3'b011 : 3'b000;
        branch        = w_exe && w_is_b;
        jal           = w_exe && (w_is_jal | w_is_jalr);
        jalr          = w_exe && w_is_jalr;
        d_func3       = (w_mem || w_wb) ? w_f3 : 3'b000;
        state_o       = r_state;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM-based RV32I control unit that sequences each instruction over multiple cycles: FETCH, DECODE, EXECUTE, then optional MEM and WB.
- Drives the same datapath control fields as the single-cycle decoder, plus PC/IR enables and a data-memory request/ready handshake.
- Adds a configurable wait-state timeout, illegal-opcode detection and fault pulses.
- Sits between the instruction register and the shared datapath (ALU, register file, data memory).

Parameters:
- MEM_WAIT_EN, 1, 1 = MEM state holds until d_ready is high; 0 = d_ready ignored and MEM lasts exactly one cycle.
- TIMEOUT_CYCLES, 16, maximum MEM cycles before abort; 0 disables the timeout; legal range 0..255.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_code  in  32  current instruction from the IR; stable from DECODE through the end of the instruction
- d_ready  in  1  data memory done/ready
- ir_en  out  1  load IR from instruction memory
- pc_en  out  1  commit PC update (pc+4, branch target or jump target per jal/jalr/branch)
- alu_controls  out  4  {funct7[5],funct3} encoding
- reg_wr_en  out  1  register file write strobe
- d_wr_en  out  1  data memory write request
- d_rd_en  out  1  data memory read request
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate
- RegWdataSel  out  3  000 ALU, 001 load data, 010 LUI imm, 011 AUIPC, 100 pc+4
- branch  out  1  branch compare enable for the PC mux
- jal  out  1  JAL target select
- jalr  out  1  JALR target select
- d_func3  out  3  load/store size and sign (funct3); 000 otherwise
- illegal_instr  out  1  one-cycle pulse on an unknown opcode
- mem_fault  out  1  one-cycle pulse on MEM timeout
- state_o  out  4  current state encoding, for debug

Behaviour:
- **States:** FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- **Reset:** state FETCH, wait counter 0. All strobes (ir_en, pc_en, reg_wr_en, d_wr_en, d_rd_en, illegal_instr, mem_fault) are 0 while reset is high. Asserting reset mid-instruction aborts it immediately; no partial write completes after reset.
- **FETCH:** ir_en=1. Next state is DECODE.
- **DECODE:** all strobes 0.
  - Opcode in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111}: go to EXE.
  - Any other opcode: illegal_instr=1 and pc_en=1 (instruction skipped), go to FETCH.
- **EXE, field values by class:**
  - R: aluSrc 0, alu {f7[5],f3}.
  - I: aluSrc 1, alu {1,f3} only when f3=101 and f7[5]=1, else {0,f3}.
  - IL/S: aluSrc 1, alu ADD (0000).
  - B: alu {0,f3}, branch=1.
  - JAL: jal=1, RegWdataSel 100.
  - JALR: jal=1, jalr=1, RegWdataSel 100, aluSrc 1.
  - LUI: RegWdataSel 010.
  - AUIPC: RegWdataSel 011.
- **EXE completion:**
  - R, I, LUI, AUIPC, JAL, JALR: reg_wr_en=1 and pc_en=1, then FETCH (3 cycles total).
  - B: pc_en=1 with branch=1, no register write, then FETCH.
  - S, IL: no strobes, then MEM.
- **MEM:** d_func3=funct3 is held. S drives d_wr_en=1; IL drives d_rd_en=1. Requests stay high until the exit cycle.
  - MEM_WAIT_EN=1: exit on the cycle d_ready=1, or when the counter reaches TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES>0.
  - MEM_WAIT_EN=0: exit after one cycle.
  - Normal exit: S goes to FETCH with pc_en=1 (4 cycles minimum); IL goes to WB.
  - Timeout exit: mem_fault=1 and pc_en=1, no WB, go to FETCH. A d_ready arriving on the timeout cycle wins; it is treated as a normal exit with no fault.
  - Wait counter: cleared on MEM entry, increments each MEM cycle, saturating.
- **WB (IL only):** RegWdataSel=001, reg_wr_en=1, pc_en=1, d_func3=funct3, then FETCH (5 cycles minimum).
- **Invariants:**
  - pc_en is asserted exactly once per instruction, including illegal and faulted ones.
  - reg_wr_en is never asserted for S or B, or after a fault.
  - In states where alu_controls is unused it is 0000, never X.
  - d_func3 is 000 outside MEM/WB.
  - All outputs are decoded combinationally from the state register plus instr_code; there are no registered outputs besides state and counter.

Test Plan:
- **add x5,x3,x4** (0x004182B3) after reset → ir_en at cycle 0; reg_wr_en=1, pc_en=1, alu_controls=0000 at cycle 2; state_o back to 0 at cycle 3.
- **lw x6,8(x2)** (0x00812303), MEM_WAIT_EN=1, d_ready high on the 3rd MEM cycle → d_rd_en high 3 cycles, d_func3=010; WB follows with reg_wr_en=1, RegWdataSel=001, pc_en=1 (7 cycles total).
- **sw, d_ready held 0, TIMEOUT_CYCLES=4** → d_wr_en high exactly 4 cycles, then mem_fault=1 and pc_en=1 for one cycle, reg_wr_en never set, state returns to FETCH.
- **Opcode 0x7F** (instr 0x0000007F) → illegal_instr=1 and pc_en=1 in DECODE; no write strobes; next state FETCH.
- **beq** (0x00208463) → branch=1, pc_en=1, alu_controls=0000, reg_wr_en=0 at EXE; **srai** (0x4030D093) → alu_controls=1101, aluSrcMuxSel=1.
- **reset asserted during MEM of sw** → d_wr_en drops in the same cycle (asynchronously); after release, state_o=0 and all strobes 0; with MEM_WAIT_EN=0, sw completes in exactly 4 cycles regardless of d_ready.
